// File: rtl/track_sel_if.sv
// Request/grant bundle between the requesters and the 8:1 selector arbiter.
interface track_sel_if;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  modport master (
    output en, req, done,
    input  sel, gnt, busy, timeout
  );

  modport slave (
    input  en, req, done,
    output sel, gnt, busy, timeout
  );
endinterface

// File: rtl/track_sel_arbiter.sv
// Round-robin owner arbiter for an 8:1 5-bit selector; grant is registered one cycle after req is sampled.
// An owner keeps the bus until done, request drop or HOLD_MAX cycles; then one RELEASE cycle precedes re-arbitration.
module track_sel_arbiter #(
  parameter int unsigned HOLD_MAX = 1023
) (
  input logic        clk,
  input logic        rst,
  track_sel_if.slave arb
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [9:0] CNT_LAST = 10'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] last_q, last_d;
  logic [7:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [9:0] cnt_q, cnt_d;

  logic [2:0] pick;
  logic       pick_vld;
  logic [2:0] idx;
  logic       early_exit;
  logic       hit_limit;

  // Scan from farthest to nearest so the nearest set bit after last wins.
  always_comb begin : rr_pick
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 8; i >= 1; i--) begin
      idx = last_q + 3'(i);
      if (arb.req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign early_exit = arb.done || !arb.req[sel_q];
  assign hit_limit  = (cnt_q == CNT_LAST);

  always_comb begin : fsm_next
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb.en && pick_vld) begin
          state_d = GRANT;
          sel_d   = pick;
          gnt_d   = 8'(1) << pick;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (early_exit || hit_limit) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = !early_exit;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        last_d  = sel_q;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= 3'd7;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign arb.sel     = sel_q;
  assign arb.gnt     = gnt_q;
  assign arb.busy    = busy_q;
  assign arb.timeout = timeout_q;

endmodule

// File: tb/tb_track_sel_arbiter.sv
// Bench for track_sel_arbiter: directed scenarios plus randomized traffic against a cycle-level owner model.
module tb_track_sel_arbiter;
  localparam int HOLD = 4;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  track_sel_if bus ();

  track_sel_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an owner index, how long it has held, and a cooldown.
  int       m_owner;
  int       m_held;
  int       m_cool;
  int       m_last;
  bit [2:0] m_sel;
  bit       m_to;

  task automatic model_step();
    bit stop_early;
    int c;
    m_to = 1'b0;
    if (rst) begin
      m_owner = -1; m_held = 0; m_cool = 0; m_last = 7; m_sel = 3'd0;
    end else if (m_owner >= 0) begin
      stop_early = bus.done || !bus.req[m_owner];
      if (stop_early || m_held == HOLD - 1) begin
        m_to    = !stop_early;
        m_last  = m_owner;
        m_owner = -1;
        m_cool  = 1;
      end else begin
        m_held++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (bus.en && bus.req != 8'h00) begin
      for (int k = 1; k <= 8; k++) begin
        c = (m_last + k) % 8;
        if (bus.req[c]) begin
          m_owner = c; m_sel = 3'(c); m_held = 0;
          break;
        end
      end
    end
  endtask

  function automatic logic [12:0] model_out();
    logic [7:0] g;
    g = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    return {m_sel, g, (m_owner >= 0), m_to};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.en = 1'b0; bus.req = 8'h00; bus.done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    rst = 1'b1;
    for (int n = 0; n < 6; n++) begin
      bus.en = 1'($urandom); bus.req = 8'($urandom); bus.done = 1'($urandom);
      tick();
      got = {bus.sel, bus.gnt, bus.busy, bus.timeout};
      vectors++;
      if (got !== 13'd0) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got sel/gnt/busy/to=%h want 0", n, got);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_first_grant();
    do_reset();
    bus.req = 8'b1000_0001; bus.en = 1'b1;
    tick();
    vectors++;
    if ({bus.gnt, bus.sel, bus.busy} !== {8'h01, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL first_grant gnt=%h sel=%0d busy=%b want gnt=01 sel=0 busy=1", bus.gnt, bus.sel, bus.busy);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    vectors++;
    if ({bus.gnt, bus.busy, bus.timeout} !== {8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL release_after_done gnt=%h busy=%b to=%b want 00/0/0", bus.gnt, bus.busy, bus.timeout);
    end
    tick(); tick();
    vectors++;
    if ({bus.gnt, bus.sel, bus.busy} !== {8'h80, 3'd7, 1'b1}) begin
      miscompares++;
      $display("FAIL second_grant gnt=%h sel=%0d busy=%b want gnt=80 sel=7 busy=1", bus.gnt, bus.sel, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] want_sel;
    logic [7:0] want_gnt;
    do_reset();
    bus.req = 8'hFF; bus.en = 1'b1;
    for (int g = 0; g < 9; g++) begin
      for (int w = 0; w < 6 && !bus.busy; w++) tick();
      want_sel = 3'(g % 8);
      want_gnt = 8'd1 << (g % 8);
      vectors++;
      if ({bus.busy, bus.sel, bus.gnt} !== {1'b1, want_sel, want_gnt}) begin
        miscompares++;
        $display("FAIL round_robin #%0d busy=%b sel=%0d gnt=%h want busy=1 sel=%0d gnt=%h",
                 g, bus.busy, bus.sel, bus.gnt, want_sel, want_gnt);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req = 8'h04; bus.en = 1'b1;
    tick();
    for (int k = 0; k < HOLD; k++) begin
      vectors++;
      if ({bus.gnt, bus.sel, bus.timeout} !== {8'h04, 3'd2, 1'b0}) begin
        miscompares++;
        $display("FAIL hold_cycle%0d gnt=%h sel=%0d to=%b want 04/2/0", k, bus.gnt, bus.sel, bus.timeout);
      end
      tick();
    end
    vectors++;
    if ({bus.gnt, bus.busy, bus.timeout} !== {8'h00, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL timeout_pulse gnt=%h busy=%b to=%b want 00/0/1", bus.gnt, bus.busy, bus.timeout);
    end
    tick();
    vectors++;
    if ({bus.gnt, bus.timeout} !== {8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL timeout_one_cycle gnt=%h to=%b want 00/0", bus.gnt, bus.timeout);
    end
    tick();
    vectors++;
    if ({bus.gnt, bus.sel} !== {8'h04, 3'd2}) begin
      miscompares++;
      $display("FAIL regrant_after_timeout gnt=%h sel=%0d want 04/2", bus.gnt, bus.sel);
    end
  endtask

  task automatic test_done_at_limit();
    // continues from the re-grant left by test_timeout (count 0 now)
    tick(); tick(); tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    vectors++;
    if ({bus.gnt, bus.busy, bus.timeout} !== {8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL done_at_limit gnt=%h busy=%b to=%b want 00/0/0", bus.gnt, bus.busy, bus.timeout);
    end
  endtask

  task automatic test_enable();
    do_reset();
    bus.req = 8'h10; bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({bus.gnt, bus.busy} !== {8'h00, 1'b0}) begin
        miscompares++;
        $display("FAIL en_low_blocks cyc=%0d gnt=%h busy=%b want 00/0", k, bus.gnt, bus.busy);
      end
    end
    bus.en = 1'b1;
    tick();
    vectors++;
    if ({bus.gnt, bus.sel} !== {8'h10, 3'd4}) begin
      miscompares++;
      $display("FAIL en_grant gnt=%h sel=%0d want 10/4", bus.gnt, bus.sel);
    end
    bus.en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (bus.gnt !== 8'h10) begin
        miscompares++;
        $display("FAIL en_drop_keeps_grant cyc=%0d gnt=%h want 10", k, bus.gnt);
      end
    end
    bus.req = 8'h00;
    tick();
    vectors++;
    if ({bus.gnt, bus.timeout} !== {8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL req_drop_release gnt=%h to=%b want 00/0", bus.gnt, bus.timeout);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 8'h20; bus.en = 1'b1;
    tick();
    vectors++;
    if ({bus.gnt, bus.sel} !== {8'h20, 3'd5}) begin
      miscompares++;
      $display("FAIL pre_reset_grant gnt=%h sel=%0d want 20/5", bus.gnt, bus.sel);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({bus.gnt, bus.sel, bus.busy, bus.timeout} !== 13'd0) begin
      miscompares++;
      $display("FAIL mid_grant_reset gnt=%h sel=%0d busy=%b to=%b want all 0", bus.gnt, bus.sel, bus.busy, bus.timeout);
    end
    rst = 1'b0; bus.req = 8'hFF;
    tick();
    vectors++;
    if ({bus.gnt, bus.sel, bus.busy} !== {8'h01, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL post_reset_grant gnt=%h sel=%0d busy=%b want 01/0/1", bus.gnt, bus.sel, bus.busy);
    end
  endtask

  task automatic test_random();
    logic [12:0] got, want;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom);
      bus.done = ($urandom_range(0, 5) == 0);
      tick();
      got  = {bus.sel, bus.gnt, bus.busy, bus.timeout};
      want = model_out();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL random cyc=%0d sel/gnt/busy/to got=%h want=%h", n, got, want);
      end
      vectors++;
      if (!$onehot0(bus.gnt) || (bus.busy !== (bus.gnt != 8'h00)) || (bus.busy && !bus.gnt[bus.sel])) begin
        miscompares++;
        $display("FAIL onehot_invariant cyc=%0d gnt=%h sel=%0d busy=%b", n, bus.gnt, bus.sel, bus.busy);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; bus.en = 1'b0; bus.req = 8'h00; bus.done = 1'b0;
    m_owner = -1; m_held = 0; m_cool = 0; m_last = 7; m_sel = 3'd0; m_to = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_grant();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_enable();
    test_reset_mid_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/track_sel_arbiter.md
TRACK_SEL_ARBITER -- requirements
Module: track_sel_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 1023: maximum cycles one grant may be held before forced release; legal range 2..1023.
REQ-002 clk  input  1  single clock; all logic is rising-edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  arbitration enable; low blocks new grants and never preempts an active one.
REQ-005 req  input  8  request per source; bit i requests 5-bit bus input i of the 8:1 selector.
REQ-006 done  input  1  current owner finished; sampled only in GRANT.
REQ-007 sel  output  3  select code driving the 8:1 5-bit selector; registered.
REQ-008 gnt  output  8  one-hot grant, all-zero when no owner; registered.
REQ-009 busy  output  1  high exactly while gnt is non-zero.
REQ-010 timeout  output  1  one-cycle pulse on forced release at HOLD_MAX.

Function
REQ-011 FSM states SHALL be IDLE, GRANT and RELEASE, with no other reachable state.
REQ-012 In IDLE with en=1 and req!=0, the block SHALL pick the first set req bit scanning last+1, last+2, ... mod 8, where last is the previously granted index.
REQ-013 The winner's index SHALL appear on sel, its one-hot on gnt and busy=1 on the cycle after req is sampled (1-cycle latency), with FSM in GRANT.
REQ-014 In IDLE with en=0 or req=0, gnt, busy and sel SHALL hold their current values (sel retains last granted index).
REQ-015 On entry to GRANT, a hold counter (10 bits) SHALL load 0 and increment by 1 each GRANT cycle.
REQ-016 GRANT SHALL exit to RELEASE on the first cycle where done=1, req[sel]=0, or count==HOLD_MAX-1.
REQ-017 timeout SHALL pulse for exactly one cycle, coincident with RELEASE, only when exit was caused solely by count==HOLD_MAX-1; if done=1 or req[sel]=0 on that same cycle, timeout stays 0.
REQ-018 In RELEASE, gnt=0 and busy=0, last SHALL update to sel, sel SHALL hold, and FSM SHALL go to IDLE next cycle unconditionally.
REQ-019 Minimum spacing between two grants SHALL therefore be 2 idle cycles (RELEASE + IDLE sampling cycle).
REQ-020 en falling during GRANT SHALL NOT affect the current grant; it only blocks arbitration in IDLE.
REQ-021 A single persistent requester SHALL be re-granted after each release (wrap-around with one requester is legal).
REQ-022 gnt SHALL never have more than one bit set; sel SHALL equal the index of the set gnt bit whenever busy=1.
REQ-023 Requests changing while in GRANT or RELEASE SHALL NOT alter sel or gnt until the next IDLE decision.

Reset
REQ-024 With rst=1 on a rising edge: FSM=IDLE, sel=0, gnt=0, busy=0, timeout=0, counter=0, last=7 (first priority index 0).
REQ-025 rst SHALL take effect mid-grant on the next edge, dropping gnt without passing through RELEASE and without a timeout pulse.
REQ-026 Outputs SHALL remain at reset values for every cycle rst is high regardless of req, en, done.

Verification
REQ-027 After reset, req=8'b1000_0001, en=1 -> next cycle gnt=8'h01, sel=0, busy=1; done pulse -> RELEASE; then gnt=8'h80, sel=7.
REQ-028 req=8'hFF held, done pulsed 1 cycle after each grant -> sel sequence 0,1,2,...,7,0 (round-robin wrap).
REQ-029 HOLD_MAX=4, req=8'h04 held, done=0 -> gnt=8'h04 for exactly 4 cycles, timeout=1 one cycle, re-grant to index 2 two cycles later.
REQ-030 HOLD_MAX=4, done=1 on 4th GRANT cycle -> release with timeout=0.
REQ-031 en=0 with req=8'h10 -> no grant; en=1 -> gnt=8'h10 next cycle; en=0 mid-grant -> grant persists until req[4] drops.
REQ-032 rst=1 during GRANT with sel=5 -> next cycle gnt=0, sel=0, busy=0, timeout=0; after release of rst with req=8'hFF -> grant index 0.
